// File: rtl/sm2201_pkg.sv
// Shared definitions for the SM2201 ISA-to-CAMAC cycle controller:
// register offsets, STATUS bit positions and FSM state encodings.
package sm2201_pkg;

    localparam logic [2:0] REG_DATA_LO = 3'd0;
    localparam logic [2:0] REG_DATA_HI = 3'd1;
    localparam logic [2:0] REG_ADDR_LO = 3'd2;
    localparam logic [2:0] REG_ADDR_HI = 3'd3;
    localparam logic [2:0] REG_CMD     = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_LAM     = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/sm2201_sync_edge.sv
// Two-flop synchroniser for an asynchronous active-low input, plus a
// one-cycle pulse on the synchronised falling edge.
module sm2201_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: every flop in a clocked block uses <= so the chain shifts by one stage per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/sm2201_camac_cycle_controller.sv
// ISA I/O window (8 ports) that runs single CAMAC dataway cycles:
// address/data setup, B1 strobe, wait for acknowledge with timeout.
module sm2201_camac_cycle_controller
    import sm2201_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR      = 10'h100,
    parameter int         SETUP_CYCLES   = 2,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic [9:0]  isa_addr,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic        isa_aen,
    input  logic [7:0]  isa_data_in,
    output logic [7:0]  isa_data_out,
    output logic        isa_data_oe,
    output logic        isa_chrdy,
    output logic [11:0] cb_addr,
    input  logic [15:0] cb_data_in,
    output logic [15:0] cb_data_out,
    output logic        cb_data_oe,
    output logic        cb_b_b1,
    input  logic        cb_prr,
    input  logic        cb_zk4,
    output logic        irq
);

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETUP_LAST   = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ior_sync, ior_fall, iow_sync, iow_fall;
    logic prr_sync, prr_fall, zk4_sync, zk4_fall;

    sm2201_sync_edge u_sync_ior (.clk(isa_clk), .rst(isa_reset), .async_in(isa_ior), .sync_out(ior_sync), .fall(ior_fall));
    sm2201_sync_edge u_sync_iow (.clk(isa_clk), .rst(isa_reset), .async_in(isa_iow), .sync_out(iow_sync), .fall(iow_fall));
    sm2201_sync_edge u_sync_prr (.clk(isa_clk), .rst(isa_reset), .async_in(cb_prr),  .sync_out(prr_sync), .fall(prr_fall));
    sm2201_sync_edge u_sync_zk4 (.clk(isa_clk), .rst(isa_reset), .async_in(cb_zk4),  .sync_out(zk4_sync), .fall(zk4_fall));

    // Acknowledge and LAM are level-sensitive; their edge pulses are not needed.
    logic unused_edges;
    assign unused_edges = prr_fall ^ zk4_fall ^ iow_sync;

    state_t        state, state_next;
    logic [SW-1:0] setup_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    data_lo, data_hi, addr_lo;
    logic [3:0]    addr_hi;
    logic          dir, done_flag, timeout_flag, status_rd_pend;

    logic       decoded, busy, wr_hit, cmd_accept, ack, lam, timeout_hit, status_clear;
    logic [2:0] offset;
    logic [7:0] rd_mux;

    assign decoded     = ~isa_aen && (isa_addr[9:3] == BASE_ADDR[9:3]);
    assign offset      = isa_addr[2:0];
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign wr_hit      = iow_fall && decoded && !busy;
    assign cmd_accept  = wr_hit && (offset == REG_CMD);
    assign ack         = ~prr_sync;
    assign lam         = ~zk4_sync;
    assign timeout_hit = (state == ST_WAIT_ACK) && !ack && (tmo_cnt == TIMEOUT_LAST);
    assign status_clear = status_rd_pend && ior_sync;

    always_ff @(posedge isa_clk) begin
        if (isa_reset) state <= ST_IDLE;
        else           state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (cmd_accept) state_next = ST_SETUP;
            ST_SETUP:    if (setup_cnt == SETUP_LAST) state_next = ST_STROBE;
            ST_STROBE:   state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack || timeout_hit) state_next = ST_DONE;
            ST_DONE:     state_next = cmd_accept ? ST_SETUP : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cb_b_b1    = (state == ST_STROBE) || (state == ST_WAIT_ACK);
        cb_data_oe = dir && busy;
    end

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            setup_cnt      <= '0;
            tmo_cnt        <= '0;
            data_lo        <= 8'h00;
            data_hi        <= 8'h00;
            addr_lo        <= 8'h00;
            addr_hi        <= 4'h0;
            dir            <= 1'b0;
            done_flag      <= 1'b0;
            timeout_flag   <= 1'b0;
            status_rd_pend <= 1'b0;
        end else begin
            setup_cnt <= (state == ST_SETUP) ? setup_cnt + SW'(1) : '0;
            if (state != ST_WAIT_ACK)   tmo_cnt <= '0;
            else if (tmo_cnt != '1)     tmo_cnt <= tmo_cnt + TW'(1);

            if (wr_hit) begin
                case (offset)
                    REG_DATA_LO: data_lo <= isa_data_in;
                    REG_DATA_HI: data_hi <= isa_data_in;
                    REG_ADDR_LO: addr_lo <= isa_data_in;
                    REG_ADDR_HI: addr_hi <= isa_data_in[3:0];
                    REG_CMD:     dir     <= isa_data_in[0];
                    default: ;
                endcase
            end
            if (state == ST_WAIT_ACK && ack && !dir)
                {data_hi, data_lo} <= cb_data_in;

            // A new command outranks completion; completion outranks a STATUS read clear.
            if (cmd_accept)             done_flag <= 1'b0;
            else if (state == ST_DONE)  done_flag <= 1'b1;
            else if (status_clear)      done_flag <= 1'b0;

            if (cmd_accept)             timeout_flag <= 1'b0;
            else if (timeout_hit)       timeout_flag <= 1'b1;
            else if (status_clear)      timeout_flag <= 1'b0;

            if (ior_fall && decoded && offset == REG_STATUS) status_rd_pend <= 1'b1;
            else if (status_clear)                            status_rd_pend <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (offset)
            REG_DATA_LO: rd_mux = data_lo;
            REG_DATA_HI: rd_mux = data_hi;
            REG_ADDR_LO: rd_mux = addr_lo;
            REG_ADDR_HI: rd_mux = {4'h0, addr_hi};
            REG_STATUS: begin
                rd_mux[STAT_BUSY]    = busy;
                rd_mux[STAT_DONE]    = done_flag;
                rd_mux[STAT_TIMEOUT] = timeout_flag;
                rd_mux[STAT_LAM]     = lam;
            end
            default: rd_mux = 8'h00;
        endcase
    end

    assign isa_data_oe  = ~ior_sync && decoded;
    assign isa_data_out = isa_data_oe ? rd_mux : 8'h00;
    assign isa_chrdy    = ~(isa_data_oe && busy &&
                            (offset == REG_DATA_LO || offset == REG_DATA_HI));
    assign cb_addr      = {addr_hi, addr_lo};
    assign cb_data_out  = {data_hi, data_lo};
    assign irq          = lam;

endmodule
